// File: rtl/add_sub_mod_pipe.sv
// Two-stage pipelined modular adder/subtractor over LANES independent lanes.
// Stage 1 forms the raw W+1-bit sum/difference, stage 2 folds it into [0, Q-1].
module add_sub_mod_pipe #(
    parameter int          W     = 24,
    parameter int unsigned Q     = 12587009,
    parameter int          LANES = 1,
    parameter int          TAGW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sub,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    input  logic [TAGW-1:0]      in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_res,
    output logic [TAGW-1:0]      out_tag
);

    localparam logic [W:0] Q_EXT = (W+1)'(Q);

    // Raw stage-1 value; for subtraction bit W acts as the sign of a - b.
    function automatic logic [W:0] raw_f(
        input logic         sub,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        return sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    // Single conditional correction brings the raw value back into [0, Q-1].
    function automatic logic [W-1:0] correct_f(
        input logic       sub,
        input logic [W:0] r
    );
        if (sub) begin
            return r[W] ? W'(r + Q_EXT) : W'(r);
        end else begin
            return (r >= Q_EXT) ? W'(r - Q_EXT) : W'(r);
        end
    endfunction

    logic                     s1_v_r;
    logic                     s1_sub_r;
    logic [TAGW-1:0]          s1_tag_r;
    logic [LANES-1:0][W:0]    s1_raw_r;
    logic                     s2_v_r;
    logic                     s1_en_s;
    logic                     s2_en_s;
    logic                     accept_s;
    logic [LANES*W-1:0]       s2_res_s;

    // Stage enables, input handshake and per-lane correction of the stage-1 value.
    always_comb begin
        s2_en_s  = !s2_v_r | out_ready;
        s1_en_s  = !s1_v_r | s2_en_s;
        accept_s = in_valid & s1_en_s;
        s2_res_s = '0;
        for (int i = 0; i < LANES; i++) begin
            s2_res_s[i*W +: W] = correct_f(s1_sub_r, s1_raw_r[i]);
        end
    end

    assign in_ready  = s1_en_s;
    assign out_valid = s2_v_r;

    // Stage 1: capture raw per-lane result, operation select and tag on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_r   <= 1'b0;
            s1_sub_r <= 1'b0;
            s1_tag_r <= '0;
            s1_raw_r <= '0;
        end else if (s1_en_s) begin
            s1_v_r <= accept_s;
            if (accept_s) begin
                s1_sub_r <= in_sub;
                s1_tag_r <= in_tag;
                for (int i = 0; i < LANES; i++) begin
                    s1_raw_r[i] <= raw_f(in_sub, in_a[i*W +: W], in_b[i*W +: W]);
                end
            end else begin
                s1_sub_r <= s1_sub_r;
            end
        end else begin
            s1_v_r <= s1_v_r;
        end
    end

    // Stage 2: result registers; held while the downstream stalls, only loaded by a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_r  <= 1'b0;
            out_res <= '0;
            out_tag <= '0;
        end else if (s2_en_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                out_res <= s2_res_s;
                out_tag <= s1_tag_r;
            end else begin
                out_res <= out_res;
            end
        end else begin
            s2_v_r <= s2_v_r;
        end
    end

endmodule

// File: tb/tb_add_sub_mod_pipe.sv
// Directed bench for add_sub_mod_pipe with two lanes: latency, modular corner
// cases, streaming, backpressure, reset with beats in flight and lane independence.
module tb_add_sub_mod_pipe;

    localparam int          W     = 24;
    localparam int unsigned Q     = 12587009;
    localparam int          LANES = 2;
    localparam int          TAGW  = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sub;
    logic [LANES*W-1:0]   in_a;
    logic [LANES*W-1:0]   in_b;
    logic [TAGW-1:0]      in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_res;
    logic [TAGW-1:0]      out_tag;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]    exp_q0[$];
    logic [W-1:0]    exp_q1[$];
    logic [TAGW-1:0] exp_tq[$];

    add_sub_mod_pipe #(.W(W), .Q(Q), .LANES(LANES), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic sub, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint s;
        if (sub) s = (longint'(a) - longint'(b) + longint'(Q)) % longint'(Q);
        else     s = (longint'(a) + longint'(b)) % longint'(Q);
        return s[W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sub, input logic [W-1:0] a0,
                         input logic [W-1:0] b0, input logic [W-1:0] a1,
                         input logic [W-1:0] b1, input logic [TAGW-1:0] tag);
        in_valid = v;
        in_sub   = sub;
        in_a     = {a1, a0};
        in_b     = {b1, b0};
        in_tag   = tag;
    endtask

    task automatic clear_queues();
        exp_q0.delete();
        exp_q1.delete();
        exp_tq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0, 8'h00);
        step();
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_res !== 48'd0 || out_tag !== 8'h00) begin
            errors++; $display("FAIL reset_out_data: got res=%h tag=%h want 0/0", out_res, out_tag);
        end
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic send_one(input string nm, input logic sub, input logic [W-1:0] a0,
                            input logic [W-1:0] b0, input logic [W-1:0] a1,
                            input logic [W-1:0] b1, input logic [TAGW-1:0] tag,
                            input logic [W-1:0] e0, input logic [W-1:0] e1);
        out_ready = 1'b1;
        drive(1'b1, sub, a0, b0, a1, b1, tag);
        step();
        drive(1'b0, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0, 8'h00);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_early_valid: got %b want 0 after 1 cycle", nm, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL %s_latency: got out_valid=%b want 1 after 2 cycles", nm, out_valid);
        end
        checks++;
        if (out_res !== {e1, e0}) begin
            errors++; $display("FAIL %s_res: got l0=%0d l1=%0d want l0=%0d l1=%0d",
                               nm, out_res[W-1:0], out_res[2*W-1:W], e0, e1);
        end
        checks++;
        if (out_tag !== tag) begin
            errors++; $display("FAIL %s_tag: got %h want %h", nm, out_tag, tag);
        end
        step();
    endtask

    task automatic test_directed();
        send_one("add_wrap", 1'b0, 24'd12587008, 24'd1, 24'd100, 24'd200, 8'h5A, 24'd0, 24'd300);
        send_one("sub_neg", 1'b1, 24'd0, 24'd1, 24'd10, 24'd3, 8'h11, 24'd12587008, 24'd7);
        send_one("sub_zero", 1'b1, 24'd5, 24'd5, 24'd3, 24'd10, 8'h22, 24'd0, 24'd12587002);
        send_one("add_zero", 1'b0, 24'd0, 24'd0, 24'd12587000, 24'd100, 8'h33, 24'd0, 24'd91);
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int first = -1;
        int last = -1;
        logic [W-1:0] a0, b0, a1, b1, e0, e1;
        logic [TAGW-1:0] et;
        logic sub;
        clear_queues();
        out_ready = 1'b1;
        for (int c = 0; c < 300 && got < 100; c++) begin
            if (out_valid && out_ready) begin
                e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front(); et = exp_tq.pop_front();
                checks++;
                if (out_res !== {e1, e0} || out_tag !== et) begin
                    errors++; $display("FAIL b2b_beat%0d: got l0=%0d l1=%0d tag=%h want l0=%0d l1=%0d tag=%h",
                                       got, out_res[W-1:0], out_res[2*W-1:W], out_tag, e0, e1, et);
                end
                got++;
                if (first < 0) first = c;
                last = c;
            end
            if (sent < 100) begin
                a0 = W'($urandom_range(Q - 1, 0)); b0 = W'($urandom_range(Q - 1, 0));
                a1 = W'($urandom_range(Q - 1, 0)); b1 = W'($urandom_range(Q - 1, 0));
                sub = 1'($urandom_range(1, 0));
                drive(1'b1, sub, a0, b0, a1, b1, TAGW'(sent));
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_in_ready: got %b want 1 at beat %0d", in_ready, sent);
                end
                if (in_ready === 1'b1) begin
                    exp_q0.push_back(model(sub, a0, b0));
                    exp_q1.push_back(model(sub, a1, b1));
                    exp_tq.push_back(TAGW'(sent));
                    sent++;
                end
            end else begin
                drive(1'b0, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0, 8'h00);
            end
            step();
        end
        checks++;
        if (got != 100) begin
            errors++; $display("FAIL b2b_count: got %0d results want 100", got);
        end
        checks++;
        if (last - first != 99) begin
            errors++; $display("FAIL b2b_rate: got span %0d cycles want 99", last - first);
        end
    endtask

    task automatic test_stall();
        int accepted = 0;
        int drained = 0;
        bit have = 1'b0;
        logic [LANES*W-1:0] held;
        logic [TAGW-1:0] held_t, et;
        logic [W-1:0] a0, e0, e1;
        clear_queues();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid) begin
                if (!have) begin
                    held = out_res; held_t = out_tag; have = 1'b1;
                end else begin
                    checks++;
                    if (out_res !== held || out_tag !== held_t) begin
                        errors++; $display("FAIL stall_hold: got res=%h tag=%h want res=%h tag=%h",
                                           out_res, out_tag, held, held_t);
                    end
                end
            end
            a0 = W'(k * 1000 + 1);
            drive(1'b1, 1'(k % 2), a0, 24'd7, W'(k + 20), W'(k), TAGW'(8'h10 + k));
            if (in_ready) begin
                exp_q0.push_back(model(1'(k % 2), a0, 24'd7));
                exp_q1.push_back(model(1'(k % 2), W'(k + 20), W'(k)));
                exp_tq.push_back(TAGW'(8'h10 + k));
                accepted++;
            end
            step();
        end
        checks++;
        if (accepted != 2) begin
            errors++; $display("FAIL stall_accepted: got %0d beats want 2", accepted);
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_full: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        drive(1'b0, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0, 8'h00);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q0.size() == 0) begin
                    errors++; $display("FAIL stall_extra: got unexpected beat tag=%h want none", out_tag);
                end else begin
                    e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front(); et = exp_tq.pop_front();
                    if (out_res !== {e1, e0} || out_tag !== et) begin
                        errors++; $display("FAIL stall_drain%0d: got res=%h tag=%h want res=%h tag=%h",
                                           drained, out_res, out_tag, {e1, e0}, et);
                    end
                end
                drained++;
            end
            step();
        end
        checks++;
        if (drained != 2) begin
            errors++; $display("FAIL stall_drain_count: got %0d beats want 2", drained);
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 24'd1, 24'd2, 24'd3, 24'd4, 8'hA1);
        step();
        drive(1'b1, 1'b1, 24'd9, 24'd2, 24'd8, 24'd4, 8'hA2);
        step();
        drive(1'b0, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0, 8'h00);
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_res !== 48'd0 || out_tag !== 8'h00) begin
            errors++; $display("FAIL rst_flight: got valid=%b res=%h tag=%h want 0/0/0",
                               out_valid, out_res, out_tag);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL rst_stale: got out_valid=%b in_ready=%b want 0/1 cycle %0d",
                                   out_valid, in_ready, c);
            end
        end
    endtask

    task automatic test_mixed_lanes();
        logic            subs[3];
        logic [W-1:0]    a0s[3], b0s[3], a1s[3], b1s[3], e0s[3], e1s[3];
        logic [W-1:0]    e0, e1;
        logic [TAGW-1:0] et;
        int idx = 0;
        int got = 0;
        subs = '{1'b0, 1'b1, 1'b0};
        a0s = '{24'd12587008, 24'd3, 24'd6293504};
        b0s = '{24'd12587008, 24'd4, 24'd6293505};
        a1s = '{24'd3, 24'd12587008, 24'd1};
        b1s = '{24'd4, 24'd12587008, 24'd12587007};
        e0s = '{24'd12587007, 24'd12587008, 24'd0};
        e1s = '{24'd7, 24'd0, 24'd12587008};
        clear_queues();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q0.size() == 0) begin
                    errors++; $display("FAIL mixed_extra: got unexpected beat tag=%h want none", out_tag);
                end else begin
                    e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front(); et = exp_tq.pop_front();
                    if (out_res[W-1:0] !== e0 || out_res[2*W-1:W] !== e1 || out_tag !== et) begin
                        errors++; $display("FAIL mixed_beat%0d: got l0=%0d l1=%0d tag=%h want l0=%0d l1=%0d tag=%h",
                                           got, out_res[W-1:0], out_res[2*W-1:W], out_tag, e0, e1, et);
                    end
                end
                got++;
            end
            if (idx < 3) begin
                drive(1'b1, subs[idx], a0s[idx], b0s[idx], a1s[idx], b1s[idx], TAGW'(8'h61 + idx));
                if (in_ready) begin
                    exp_q0.push_back(e0s[idx]);
                    exp_q1.push_back(e1s[idx]);
                    exp_tq.push_back(TAGW'(8'h61 + idx));
                    idx++;
                end
            end else begin
                drive(1'b0, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0, 8'h00);
            end
            step();
        end
        checks++;
        if (got != 3) begin
            errors++; $display("FAIL mixed_count: got %0d beats want 3", got);
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0, 8'h00);
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_mixed_lanes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
